// File: rtl/vc_fifo_bank_pkg.sv
// vc_fifo_bank_pkg: default sizing and width helpers shared by the VC FIFO bank
package vc_fifo_bank_pkg;
  localparam int BW_DEF = 6;
  localparam int DEPTH_DEF = 4;
  localparam int NUM_VC_DEF = 2;
  localparam int TOL_DEF = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // A single channel still needs a 1-bit index port
  function automatic int vc_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vc_fifo_bank_ctrl.sv
// vc_fifo_ctrl: per-channel pointers, occupancy, flags and sticky error
module vc_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int TOL = 1,
  parameter int AW = 2,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          error
);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(DEPTH - TOL);
  assign almost_empty = count <= CW'(TOL);
  // A full channel still accepts a write when a read frees a slot on the same edge
  assign rd_en = rd_req && !empty;
  assign wr_en = wr_req && (!full || rd_en);
  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + CW'(wr_en) - CW'(rd_en);
      error <= error | (wr_req && !wr_en) | (rd_req && !rd_en);
    end
endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NUM_VC independent FIFOs sharing one write and one read port
module vc_fifo_bank
  import vc_fifo_bank_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int TOL = TOL_DEF,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int VCW = vc_width(NUM_VC)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 wr,
  input  logic [VCW-1:0]       wr_vc,
  input  logic [BW-1:0]        data_in,
  input  logic                 rd,
  input  logic [VCW-1:0]       rd_vc,
  output logic [BW-1:0]        data_out,
  output logic                 valid_out,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC-1:0]    almost_empty,
  output logic [NUM_VC-1:0]    error_output,
  output logic [NUM_VC*CW-1:0] occupancy
);
  logic [NUM_VC-1:0] wr_req, rd_req, wr_en, rd_en;
  logic [AW-1:0] wr_ptrs [NUM_VC];
  logic [AW-1:0] rd_ptrs [NUM_VC];
  logic [CW-1:0] counts [NUM_VC];
  logic [BW-1:0] mem [NUM_VC*DEPTH];
  logic [VCW+AW-1:0] wa, ra;
  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    // An out-of-range VC index matches no channel and is thereby ignored
    assign wr_req[g] = wr && wr_vc == VCW'(g);
    assign rd_req[g] = rd && rd_vc == VCW'(g);
    assign occupancy[g*CW +: CW] = counts[g];
    vc_fifo_ctrl #(.DEPTH(DEPTH), .TOL(TOL), .AW(AW), .CW(CW)) u_ctrl (
      .clk(clk),
      .reset_L(reset_L),
      .wr_req(wr_req[g]),
      .rd_req(rd_req[g]),
      .wr_en(wr_en[g]),
      .rd_en(rd_en[g]),
      .wr_ptr(wr_ptrs[g]),
      .rd_ptr(rd_ptrs[g]),
      .count(counts[g]),
      .full(full[g]),
      .empty(empty[g]),
      .almost_full(almost_full[g]),
      .almost_empty(almost_empty[g]),
      .error(error_output[g])
    );
  end
  assign wa = {wr_vc, wr_ptrs[wr_vc]};
  assign ra = {rd_vc, rd_ptrs[rd_vc]};
  // Storage is never cleared; the per-channel counts decide what is live
  always_ff @(posedge clk)
    if (|wr_en) mem[wa] <= data_in;
  // Registered read port; data_out holds when no read is accepted
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      data_out <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |rd_en;
      if (|rd_en) data_out <= mem[ra];
    end
endmodule
